// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; multi-cycle mult/div, single-cycle mthi/mtlo.
// Optional madd accumulate (md_op=7) is built only when MDU_MADD_EN is defined.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   hi_p_q, hi_p_d;
  logic [31:0]   lo_p_q, lo_p_d;
  logic          wr_q, wr_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] div_q;
  logic [31:0] div_r;

  // Low 64 bits of the sign-extended product equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes: avoids the MIN/-1 overflow corner.
  assign sgn   = (md_op == 3'd3);
  assign a_neg = sgn & A[31];
  assign b_neg = sgn & B[31];
  assign a_mag = a_neg ? (~A + 32'd1) : A;
  assign b_mag = b_neg ? (~B + 32'd1) : B;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign div_q = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign div_r = a_neg ? (~r_mag + 32'd1) : r_mag;

`ifdef MDU_MADD_EN
  logic [63:0] mac;
  assign mac = {hi_q, lo_q} + prod_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'd1: begin
              {hi_p_d, lo_p_d} = prod_s;
              cnt_d   = MULT_N;
              wr_d    = 1'b1;
              state_d = RUN;
            end
            3'd2: begin
              {hi_p_d, lo_p_d} = prod_u;
              cnt_d   = MULT_N;
              wr_d    = 1'b1;
              state_d = RUN;
            end
            3'd3, 3'd4: begin
              hi_p_d  = div_r;
              lo_p_d  = div_q;
              cnt_d   = DIV_N;
              wr_d    = |B;
              state_d = RUN;
            end
            3'd5: hi_d = A;
            3'd6: lo_d = A;
`ifdef MDU_MADD_EN
            3'd7: begin
              {hi_p_d, lo_p_d} = mac;
              cnt_d   = MULT_N;
              wr_d    = 1'b1;
              state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = hi_p_q;
            lo_d = lo_p_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_p_q  <= '0;
      lo_p_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
      wr_q    <= wr_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide unit in the EX stage of the pipelined MIPS core.
- Owns the HI and LO registers and feeds the EX-stage result select, which chooses between the ALU output, HI and LO (AO_E).
- Runs mult/multu/div/divu as multi-cycle operations and mthi/mtlo as single-cycle writes.
- Exposes busy so the hazard unit stalls any mult/div/mfhi/mflo/mthi/mtlo in D while an operation is outstanding.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (and madd/maddu when enabled); legal range ≥1.
- DIV_CYCLES, 10, cycles busy stays high for div/divu; legal range ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX-stage instruction is an MDU op; qualifies md_op.
- md_op  input  3  1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=madd; 0 = no op.
- A  input  32  rs operand, forwarded value.
- B  input  32  rt operand, forwarded value.
- busy  output  1  multi-cycle operation in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset: busy=0, HI=0, LO=0, internal counter=0, pending result discarded. Reset in the middle of an operation aborts it; HI/LO read 0 on the next cycle.
- Internal state:
  - IDLE: counter==0, busy=0.
  - RUN: counter>0, busy=1.
  - Registered result pair: hi_p, lo_p.
- Start of a multi-cycle op: when start=1 and md_op∈{1,2,3,4} are sampled in IDLE at the edge closing cycle t:
  - hi_p/lo_p capture the full result computed from A and B as sampled.
  - counter loads N (MULT_CYCLES or DIV_CYCLES).
  - busy=1 for cycles t+1 … t+N.
- Completion: at the edge closing cycle t+N, counter reaches 0, busy→0, and HI←hi_p, LO←lo_p.
  - New values are visible in cycle t+N+1.
  - HI/LO keep their old values throughout RUN.
- Multiply:
  - mult: signed 32x32→64.
  - multu: unsigned 32x32→64.
  - HI = bits [63:32], LO = bits [31:0].
- Divide:
  - div: signed; quotient truncated toward zero → LO; remainder takes the sign of the dividend → HI.
  - divu: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divide by zero (B=0): full DIV_CYCLES busy period still occurs; at completion HI and LO are left unchanged.
- mthi/mtlo (md_op 5/6) with start=1 in IDLE:
  - HI←A (or LO←A) at the edge closing cycle t.
  - busy never asserts; the other register is untouched.
- start during RUN, for any md_op: ignored, no state change. The hazard unit guarantees this never occurs.
- start=1 with md_op=0, or md_op=7 when the feature is disabled: no-op.
- busy is a pure register output with no combinational path from start. The stall logic ORs start and busy itself.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - md_op=7 is madd: {HI,LO} ← {HI,LO} + signed(A)*signed(B), 64-bit wrap-around.
  - The sum uses the HI/LO values at the start edge.
  - Same MULT_CYCLES busy timing as mult.
- Undefined: md_op=7 is a no-op; no accumulate adder is synthesized.

Test Plan:
- Reset held 2 cycles after arbitrary prior HI/LO writes → busy=0, HI=0, LO=0.
- mult A=0xFFFFFFFD (-3), B=5, start at cycle 0:
  - busy=1 in cycles 1–5 and 0 in cycle 6.
  - HI=0xFFFFFFFF, LO=0xFFFFFFF1 from cycle 6; old HI/LO held in cycles 1–5.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- Divide results after 10 busy cycles each:
  - div A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
  - div by B=0 → HI/LO unchanged after 10 busy cycles.
- Single-cycle and ignored starts:
  - mthi A=0x12345678 → HI=0x12345678 next cycle, LO unchanged, busy never 1.
  - start mult during RUN → ignored.
  - reset at busy cycle 3 of a div → busy=0, HI=LO=0 next cycle.
- With MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, madd A=1, B=1 → HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves HI/LO unchanged and busy=0.
